// File: rtl/serial_byte_rx.sv
// Framed serial byte receiver: start, 8 data bits LSB first, even parity, stop.
// Good bytes are held for display; a status view exposes error flags and a count of good frames.
module serial_byte_rx (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  logic clk;
  logic rst;
  logic sdata;
  logic view;
  logic clr;
  logic unused_ok;

  assign clk       = io_in[0];
  assign rst       = io_in[1];
  assign sdata     = io_in[2];
  assign view      = io_in[4];
  assign clr       = io_in[5];
  assign unused_ok = &{1'b0, io_in[3], io_in[7:6]};

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [7:0] data_q, data_d;
  logic       frame_err_q, frame_err_d;
  logic       parity_err_q, parity_err_d;
  logic       rdy_tgl_q, rdy_tgl_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic       parity_bad;
  logic       busy;

  assign parity_bad = par_q ^ (^shift_q);
  assign busy       = (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    par_d        = par_q;
    data_d       = data_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    rdy_tgl_d    = rdy_tgl_q;
    good_cnt_d   = good_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (!sdata) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        shift_d[idx_q] = sdata;
        if (idx_q == 3'd7) state_d = S_PARITY;
        else               idx_d   = idx_q + 3'd1;
      end
      S_PARITY: begin
        par_d   = sdata;
        state_d = S_STOP;
      end
      S_STOP: begin
        if (parity_bad) parity_err_d = 1'b1;
        if (sdata) begin
          state_d = S_IDLE;
          if (!parity_bad) begin
            data_d     = shift_q;
            rdy_tgl_d  = ~rdy_tgl_q;
            good_cnt_d = good_cnt_q + 4'd1;
          end
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        // A held-low line must return high before a new start is honoured.
        if (sdata) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (clr) begin
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
      good_cnt_d   = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      data_q       <= 8'h00;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      rdy_tgl_q    <= 1'b0;
      good_cnt_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      data_q       <= data_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      rdy_tgl_q    <= rdy_tgl_d;
      good_cnt_q   <= good_cnt_d;
    end
  end

  assign io_out = view ? {frame_err_q, parity_err_q, busy, rdy_tgl_q, good_cnt_q} : data_q;

endmodule

// File: tb/tb_serial_byte_rx.sv
// Bench for serial_byte_rx: directed frames from the test plan plus randomized frames
// checked against a frame-level reference model of the receiver's visible state.
module tb_serial_byte_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sdata = 1'b1;
  logic       view = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] junk = 3'b000;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_data;
  logic       m_rdy;
  logic       m_ferr;
  logic       m_perr;
  logic [3:0] m_cnt;
  logic [7:0] exp_q[$];

  assign io_in = {junk[2:1], clr, view, junk[0], sdata, rst, clk};

  serial_byte_rx dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_status(input logic busy_exp);
    return {m_ferr, m_perr, busy_exp, m_rdy, m_cnt};
  endfunction

  task automatic model_reset();
    m_data = 8'h00;
    m_rdy  = 1'b0;
    m_ferr = 1'b0;
    m_perr = 1'b0;
    m_cnt  = 4'd0;
  endtask

  // Reads both views at a falling edge without disturbing reception.
  task automatic read_views(output logic [7:0] d, output logic [7:0] s);
    view = 1'b0;
    #1 d = io_out;
    view = 1'b1;
    #1 s = io_out;
    view = 1'b0;
  endtask

  // Drives one 11-bit frame starting at a falling edge, ends at the falling edge after the stop edge.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input logic clr_stop, output logic [10:0] trace);
    logic [10:0] bits;
    logic        good;
    bits = {stop, par, b, 1'b0};
    for (int k = 0; k < 11; k++) begin
      sdata = bits[k];
      clr   = (k == 10) && clr_stop;
      junk  = 3'($urandom);
      @(negedge clk);
      clr  = 1'b0;
      view = 1'b1;
      #1 trace[k] = io_out[5];
      view = 1'b0;
    end
    good = stop && (par == (^b));
    if (good) begin
      m_data = b;
      m_rdy  = ~m_rdy;
      m_cnt  = m_cnt + 4'd1;
    end
    if (par != (^b)) m_perr = 1'b1;
    if (!stop) m_ferr = 1'b1;
    if (clr_stop) begin
      m_ferr = 1'b0;
      m_perr = 1'b0;
      m_cnt  = 4'd0;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d, s;
    rst = 1'b1;
    sdata = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    read_views(d, s);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", d); end
    checks++;
    if (s !== 8'h00) begin failures++; $display("FAIL reset_status got=%h exp=00", s); end
  endtask

  task automatic test_good_a5();
    logic [7:0]  d, s;
    logic [10:0] tr;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, tr);
    read_views(d, s);
    checks++;
    if (tr !== 11'h3FF) begin failures++; $display("FAIL a5_busy_trace got=%b exp=%b", tr, 11'h3FF); end
    checks++;
    if (d !== 8'hA5) begin failures++; $display("FAIL a5_data got=%h exp=a5", d); end
    checks++;
    if (s !== 8'h11) begin failures++; $display("FAIL a5_status got=%h exp=11", s); end
  endtask

  task automatic test_parity_err();
    logic [7:0]  d, s;
    logic [10:0] tr;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, tr);
    read_views(d, s);
    checks++;
    if (d !== 8'hA5) begin failures++; $display("FAIL perr_data got=%h exp=a5", d); end
    checks++;
    if (s !== exp_status(1'b0)) begin failures++; $display("FAIL perr_status got=%h exp=%h", s, exp_status(1'b0)); end
  endtask

  task automatic test_frame_err();
    logic [7:0]  d, s;
    logic [10:0] tr;
    int          low_busy;
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, tr);
    read_views(d, s);
    checks++;
    if (tr !== 11'h7FF) begin failures++; $display("FAIL ferr_busy_trace got=%b exp=%b", tr, 11'h7FF); end
    checks++;
    if (s !== exp_status(1'b1)) begin failures++; $display("FAIL ferr_status got=%h exp=%h", s, exp_status(1'b1)); end
    low_busy = 0;
    sdata = 1'b0;
    repeat (5) begin
      @(negedge clk);
      read_views(d, s);
      if (s[5] === 1'b1) low_busy++;
    end
    checks++;
    if (low_busy != 5) begin failures++; $display("FAIL ferr_hold_low_busy got=%0d exp=5", low_busy); end
    sdata = 1'b1;
    @(negedge clk);
    read_views(d, s);
    checks++;
    if (s !== exp_status(1'b0)) begin failures++; $display("FAIL ferr_release_status got=%h exp=%h", s, exp_status(1'b0)); end
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, tr);
    read_views(d, s);
    checks++;
    if (d !== 8'h81) begin failures++; $display("FAIL ferr_recover_data got=%h exp=81", d); end
    checks++;
    if (s !== exp_status(1'b0)) begin failures++; $display("FAIL ferr_recover_status got=%h exp=%h", s, exp_status(1'b0)); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  d, s;
    logic [10:0] tr;
    logic [3:0]  cnt0;
    logic        rdy0;
    int          bad_trace;
    cnt0 = m_cnt;
    rdy0 = m_rdy;
    bad_trace = 0;
    for (int i = 0; i < 16; i++) begin
      send_frame(8'h00, 1'b0, 1'b1, 1'b0, tr);
      if (tr !== 11'h3FF) bad_trace++;
    end
    read_views(d, s);
    checks++;
    if (bad_trace != 0) begin failures++; $display("FAIL b2b_busy_traces got=%0d bad exp=0", bad_trace); end
    checks++;
    if (s[3:0] !== cnt0) begin failures++; $display("FAIL b2b_cnt_wrap got=%h exp=%h", s[3:0], cnt0); end
    checks++;
    if (s[4] !== rdy0) begin failures++; $display("FAIL b2b_rdy got=%b exp=%b", s[4], rdy0); end
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL b2b_data got=%h exp=00", d); end
  endtask

  task automatic test_clr();
    logic [7:0]  d, s, d0;
    logic [10:0] tr;
    d0 = m_data;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, tr);
    read_views(d, s);
    checks++;
    if (d !== d0) begin failures++; $display("FAIL clr_data got=%h exp=%h", d, d0); end
    checks++;
    if (s !== {3'b000, m_rdy, 4'h0}) begin failures++; $display("FAIL clr_status got=%h exp=%h", s, {3'b000, m_rdy, 4'h0}); end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  d, s;
    logic [10:0] tr;
    sdata = 1'b0;
    @(negedge clk);
    for (int k = 1; k < 5; k++) begin
      sdata = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    read_views(d, s);
    checks++;
    if ({d, s} !== 16'h0000) begin failures++; $display("FAIL midreset_outputs got=%h_%h exp=00_00", d, s); end
    rst = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, tr);
    read_views(d, s);
    checks++;
    if (d !== 8'h5A) begin failures++; $display("FAIL midreset_data got=%h exp=5a", d); end
    checks++;
    if (s !== 8'h11) begin failures++; $display("FAIL midreset_status got=%h exp=11", s); end
  endtask

  task automatic test_random();
    logic [7:0]  d, s, b, exp_d;
    logic [10:0] tr;
    logic        pbad, sbad, cl;
    for (int n = 0; n < 40; n++) begin
      b    = 8'($urandom);
      pbad = ($urandom_range(0, 3) == 0);
      sbad = ($urandom_range(0, 5) == 0);
      cl   = ($urandom_range(0, 7) == 0);
      if (!pbad && !sbad) exp_q.push_back(b);
      send_frame(b, (^b) ^ pbad, !sbad, cl, tr);
      read_views(d, s);
      exp_d = (exp_q.size() > 0) ? exp_q[$] : m_data;
      checks++;
      if (d !== exp_d) begin failures++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, d, exp_d); end
      checks++;
      if (s !== exp_status(sbad)) begin failures++; $display("FAIL rnd_status n=%0d got=%h exp=%h", n, s, exp_status(sbad)); end
      checks++;
      if (tr !== {sbad, 10'h3FF}) begin failures++; $display("FAIL rnd_busy n=%0d got=%b", n, tr); end
      sdata = 1'b1;
      repeat (sbad ? 1 : $urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_a5();
    test_parity_err();
    test_frame_err();
    test_back_to_back();
    test_clr();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
